motor_pwm_generator: RTL and testbench

Converts the four 8-bit motor rates produced by the motor mixer into four servo-style ESC PWM signals (1000–2000 µs pulse, fixed frame period). It is the consumer end of the mixer's `motor_N_rate` interface and drives the FPGA pins to the ESCs. Rates are sampled once per frame so a pulse is never altered mid-flight, and a one-cycle frame strobe is exported for upstream pacing.

---
 rtl/motor_pwm_generator_if.sv | 31 +++
 rtl/motor_pwm_generator.sv | 129 ++++++++++++
 tb/tb_motor_pwm_generator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/motor_pwm_generator_if.sv
// Mixer-to-ESC link: arm and four motor rates in, four PWM pins and the
// frame strobe out.
interface motor_pwm_generator_if #(
    parameter int MOTOR_RATE_BIT_WIDTH = 8
);
    logic                            arm;
    logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate;
    logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate;
    logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate;
    logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate;
    logic                            pwm_1;
    logic                            pwm_2;
    logic                            pwm_3;
    logic                            pwm_4;
    logic                            period_start;

    // The mixer side drives arm and rates and watches the frame strobe.
    modport master (
        output arm,
        output motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
        input  pwm_1, pwm_2, pwm_3, pwm_4,
        input  period_start
    );

    modport slave (
        input  arm,
        input  motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
        output pwm_1, pwm_2, pwm_3, pwm_4,
        output period_start
    );
endinterface

// File: rtl/motor_pwm_generator.sv
// Four-channel servo-style ESC PWM generator: rates are latched once per frame,
// pulses of MIN_PULSE_US + rate*(MAX-MIN)/256 microseconds start together.
module motor_pwm_generator #(
    parameter int CLK_FREQ_HZ          = 38_000_000,
    parameter int PWM_PERIOD_US        = 2500,
    parameter int MIN_PULSE_US         = 1000,
    parameter int MAX_PULSE_US         = 2000,
    parameter int MOTOR_RATE_BIT_WIDTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  resetn,
    motor_pwm_generator_if.slave  bus
);
    localparam int CLK_DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RATE_W  = MOTOR_RATE_BIT_WIDTH;
    localparam int SPAN    = MAX_PULSE_US - MIN_PULSE_US;
    localparam int SPAN_W  = (SPAN > 1) ? $clog2(SPAN + 1) : 1;
    localparam int PROD_W  = RATE_W + SPAN_W;
    // Widths and the microsecond counter share one 12-bit domain, so the
    // frame period must stay below 4096 us.
    localparam int W_W     = 12;

    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(CLK_DIV - 1);
    localparam logic [W_W-1:0]    US_LAST = W_W'(PWM_PERIOD_US - 1);
    localparam logic [W_W-1:0]    W_MIN   = W_W'(MIN_PULSE_US);
    localparam logic [PROD_W-1:0] SPAN_P  = PROD_W'(SPAN);

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_LATCH,
        STATE_RUN
    } state_t;

    state_t                       state;
    logic [PS_W-1:0]              prescaler;
    logic [W_W-1:0]               us_cnt;
    logic [3:0][W_W-1:0]          width_q;
    logic [3:0]                   pwm_q;
    logic                         period_start_q;

    logic [3:0][RATE_W-1:0]       rate_v;
    logic                         us_tick;
    logic [W_W-1:0]               us_next;

    function automatic logic [W_W-1:0] rate_to_width(input logic [RATE_W-1:0] rate);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(rate) * SPAN_P;
        return W_MIN + W_W'(prod >> RATE_W);
    endfunction

    assign rate_v  = {bus.motor_4_rate, bus.motor_3_rate, bus.motor_2_rate, bus.motor_1_rate};
    assign us_tick = (prescaler == PS_LAST);
    assign us_next = us_cnt + 1'b1;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values; the width registers are reset too so the
    // block comes up fully deterministic.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            state          <= STATE_IDLE;
            prescaler      <= '0;
            us_cnt         <= '0;
            width_q        <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else if (!bus.arm) begin
            // Disarm truncates any pulse in flight.
            state          <= STATE_IDLE;
            prescaler      <= '0;
            us_cnt         <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    prescaler      <= '0;
                    us_cnt         <= '0;
                    pwm_q          <= '0;
                    period_start_q <= 1'b1;
                    state          <= STATE_LATCH;
                end

                STATE_LATCH: begin
                    for (int i = 0; i < 4; i++) begin
                        width_q[i] <= rate_to_width(rate_v[i]);
                    end
                    pwm_q          <= '1;
                    prescaler      <= '0;
                    us_cnt         <= '0;
                    period_start_q <= 1'b0;
                    state          <= STATE_RUN;
                end

                STATE_RUN: begin
                    if (us_tick) begin
                        prescaler <= '0;
                        for (int i = 0; i < 4; i++) begin
                            if (us_next == width_q[i]) begin
                                pwm_q[i] <= 1'b0;
                            end
                        end
                        if (us_cnt == US_LAST) begin
                            us_cnt         <= '0;
                            period_start_q <= 1'b1;
                            state          <= STATE_LATCH;
                        end else begin
                            us_cnt <= us_next;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end

                default: begin
                    state <= STATE_IDLE;
                    pwm_q <= '0;
                end
            endcase
        end
    end

    assign bus.pwm_1        = pwm_q[0];
    assign bus.pwm_2        = pwm_q[1];
    assign bus.pwm_3        = pwm_q[2];
    assign bus.pwm_4        = pwm_q[3];
    assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_motor_pwm_generator.sv
// Directed bench for motor_pwm_generator at a 4 MHz clock (CLK_DIV = 4):
// pulse widths, frame length, mid-frame rate change, disarm and async reset.
module tb_motor_pwm_generator;
    localparam int CLK_DIV     = 4;
    localparam int FRAME_LEN   = 2500 * CLK_DIV + 1;
    localparam int FRAME_LIMIT = FRAME_LEN + 200;

    logic sys_clk = 1'b0;
    logic resetn  = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    motor_pwm_generator_if #(.MOTOR_RATE_BIT_WIDTH(8)) bus ();

    motor_pwm_generator #(
        .CLK_FREQ_HZ(4_000_000),
        .PWM_PERIOD_US(2500),
        .MIN_PULSE_US(1000),
        .MAX_PULSE_US(2000),
        .MOTOR_RATE_BIT_WIDTH(8)
    ) dut (
        .sys_clk(sys_clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    logic [3:0] pwm_v;
    assign pwm_v = {bus.pwm_4, bus.pwm_3, bus.pwm_2, bus.pwm_1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_rates(input logic [3:0][7:0] r);
        bus.motor_1_rate = r[0];
        bus.motor_2_rate = r[1];
        bus.motor_3_rate = r[2];
        bus.motor_4_rate = r[3];
    endtask

    // Starts on the falling edge where period_start is seen and runs to the next
    // one, counting high cycles per channel; rates change at cycle chg_at.
    task automatic run_frame(input int chg_at, input logic [3:0][7:0] chg_rates,
                             output int h1, output int h2, output int h3, output int h4,
                             output int len, output logic [3:0] first_pwm);
        h1 = 0; h2 = 0; h3 = 0; h4 = 0; len = 0; first_pwm = '0;
        do begin
            @(negedge sys_clk);
            len++;
            if (len == 1) first_pwm = pwm_v;
            if (pwm_v[0]) h1++;
            if (pwm_v[1]) h2++;
            if (pwm_v[2]) h3++;
            if (pwm_v[3]) h4++;
            if (len == chg_at) set_rates(chg_rates);
        end while (!bus.period_start && len < FRAME_LIMIT);
    endtask

    initial begin
        int h1, h2, h3, h4, len, seen;
        logic [3:0] first;

        // Reset held with arm high and rates 200: everything stays low.
        bus.arm = 1'b1;
        set_rates({8'd200, 8'd200, 8'd200, 8'd200});
        repeat (5) @(negedge sys_clk);
        check("reset_pwm", 32'(pwm_v), 32'd0);
        check("reset_period_start", 32'(bus.period_start), 32'd0);

        resetn = 1'b1;
        @(negedge sys_clk);
        check("release_period_start", 32'(bus.period_start), 32'd1);
        check("release_pwm_low", 32'(pwm_v), 32'd0);

        // Frame 1 at rate 200 (1781 us); next-frame rates change mid-pulse.
        run_frame(100, {8'd255, 8'd128, 8'd64, 8'd0}, h1, h2, h3, h4, len, first);
        check("f1_rise", 32'(first), 32'hF);
        check("f1_pwm1_r200", 32'(h1), 32'd7124);
        check("f1_pwm4_r200", 32'(h4), 32'd7124);
        check("f1_len", 32'(len), 32'(FRAME_LEN));

        // Frame 2: rates 0/64/128/255; motor 1 changes to 255 at cycle 2000.
        run_frame(2000, {8'd255, 8'd128, 8'd64, 8'd255}, h1, h2, h3, h4, len, first);
        check("f2_pwm1_r0", 32'(h1), 32'd4000);
        check("f2_pwm2_r64", 32'(h2), 32'd5000);
        check("f2_pwm3_r128", 32'(h3), 32'd6000);
        check("f2_pwm4_r255", 32'(h4), 32'd7984);
        check("f2_len", 32'(len), 32'(FRAME_LEN));

        // Frame 3: the mid-frame change to motor 1 now applies.
        run_frame(-1, '0, h1, h2, h3, h4, len, first);
        check("f3_pwm1_r255", 32'(h1), 32'd7984);
        check("f3_pwm2_r64", 32'(h2), 32'd5000);
        check("f3_len", 32'(len), 32'(FRAME_LEN));

        // Disarm mid-pulse.
        repeat (1000) @(negedge sys_clk);
        check("pre_disarm_pwm", 32'(pwm_v), 32'hF);
        bus.arm = 1'b0;
        @(negedge sys_clk);
        check("disarm_pwm", 32'(pwm_v), 32'd0);
        check("disarm_period_start", 32'(bus.period_start), 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (bus.period_start || pwm_v != 4'h0) seen++;
        end
        check("disarm_quiet", 32'(seen), 32'd0);

        // Re-arm: strobe one edge later, then a full frame.
        bus.arm = 1'b1;
        @(negedge sys_clk);
        check("rearm_period_start", 32'(bus.period_start), 32'd1);
        run_frame(-1, '0, h1, h2, h3, h4, len, first);
        check("f4_rise", 32'(first), 32'hF);
        check("f4_pwm1", 32'(h1), 32'd7984);
        check("f4_pwm3", 32'(h3), 32'd6000);
        check("f4_len", 32'(len), 32'(FRAME_LEN));

        // Asynchronous reset between edges while pulses are high.
        repeat (500) @(negedge sys_clk);
        check("pre_reset_pwm", 32'(pwm_v), 32'hF);
        #2 resetn = 1'b0;
        #1;
        check("async_reset_pwm", 32'(pwm_v), 32'd0);
        check("async_reset_period_start", 32'(bus.period_start), 32'd0);
        @(negedge sys_clk);
        resetn = 1'b1;
        seen = 0;
        do begin
            @(negedge sys_clk);
            seen++;
        end while (!bus.period_start && seen < 10);
        check("post_reset_strobe_delay", 32'(seen), 32'd1);
        run_frame(-1, '0, h1, h2, h3, h4, len, first);
        check("f5_rise", 32'(first), 32'hF);
        check("f5_pwm2", 32'(h2), 32'd5000);
        check("f5_len", 32'(len), 32'(FRAME_LEN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
